mac_skew_feeder: RTL and testbench
==================================

Name: mac_skew_feeder

Overview:
- Edge feeder for the systolic MAC array.
- Accepts flattened vectors of IN_DIM elements one at a time from an upstream producer (window slider or weight unit). For the k-th vector it emits a skewed row of OUT_DIM elements, with the vector shifted by k element positions and zero-padded.
- One instance feeds the array's left edge (image windows); a second feeds the top edge (kernels).
- Drives the upstream next-item handshake and reports per-row and whole-batch completion.

Parameters:
- DATA_WIDTH, 8, bits per element.
- IN_DIM, 16, elements per input vector (K_H*K_W).
- OUT_DIM, 16+49-1=64, elements per skewed output row. Derived N = OUT_DIM-IN_DIM+1 is the maximum number of vectors per batch.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new batch.
- vector_valid  in  1  in_vector holds a valid vector this cycle.
- vectors_complete  in  1  level; producer has no more vectors.
- in_vector  in  DATA_WIDTH*IN_DIM  element e at bits [DATA_WIDTH*e +: DATA_WIDTH].
- out_vector  out  DATA_WIDTH*OUT_DIM  skewed row; element p at [DATA_WIDTH*p +: DATA_WIDTH].
- ready  out  1  feeder can accept a vector (producer's next-item request).
- output_done  out  1  one-cycle pulse; out_vector holds a new row.
- all_done  out  1  sticky; batch finished.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, index=0.
  - out_vector=0, ready=0, output_done=0, all_done=0.
- States: IDLE, WAIT, EMIT, DONE. All outputs are registered.
- IDLE: ready=0. start -> WAIT, with index=0, out_vector=0, all_done=0.
- WAIT: ready=1.
  - vector_valid=1: capture in_vector. Next cycle, out_vector element (index+e) = in_vector element e for e in 0..IN_DIM-1; all other elements = 0. Go to EMIT.
  - vector_valid=0 and vectors_complete=1: go to DONE.
- EMIT (exactly one cycle):
  - output_done=1, ready=0; index increments.
  - Next state is DONE if vectors_complete=1 or index has reached N; otherwise WAIT.
- DONE: all_done=1, ready=0; out_vector holds the last row. start -> WAIT with a fresh batch (index=0, out_vector=0, all_done=0).
- Latency: capture to output_done is 1 cycle. Maximum throughput is one vector per 2 cycles.
- out_vector holds its value until the next row is emitted, or until start/reset clears it.
- Simultaneous vector_valid and vectors_complete in WAIT: the vector is accepted and emitted, then the feeder goes to DONE.
- start in any state (including mid-batch): restarts the batch immediately. Any pending capture is discarded and output_done is suppressed that cycle.
- Extra vectors beyond N: never accepted, because DONE is entered after the N-th row.
- vector_valid while ready=0: ignored.
- Reset mid-operation: immediate return to the reset values above.
- No arithmetic; a pure data placement with zero fill.

Decomposition:
- Shared package:
  - element width constant DATA_WIDTH;
  - function computing N from IN_DIM and OUT_DIM;
  - clog2-based index width;
  - state enum {IDLE, WAIT, EMIT, DONE}, also reused by the MAC array and activation layer.
- Natural sub-module: skew_shifter. It is combinational and places the IN_DIM-element vector at an element offset within an OUT_DIM-element zero field.
- Everything else (FSM, index counter) stays in the top level.

Test Plan:
All cases use DATA_WIDTH=8, IN_DIM=4, OUT_DIM=6 (N=3).
- Reset: hold rst=0 -> out_vector=0, ready=0, output_done=0, all_done=0. Release rst without start -> outputs unchanged.
- Three-vector batch:
  - start, then vectors 0x04030201, 0x08070605, 0x0C0B0A09, each presented when ready=1.
  - Required: out_vector = 0x000004030201, 0x000807060500, 0x0C0B0A090000, each with a single output_done pulse one cycle after capture.
  - all_done=1 after the third row; ready stays 0 afterwards.
- Early complete:
  - start, one vector 0x44332211, then vectors_complete=1.
  - Required: one row 0x000044332211, then all_done=1 with out_vector held.
- Simultaneous valid+complete: vector 0xDDCCBBAA with vectors_complete=1 in the same cycle -> row 0x0000DDCCBBAA emitted, then all_done.
- Restart:
  - start mid-batch, after one row.
  - Required: out_vector=0, all_done=0. The next vector 0x01010101 emits as 0x000001010101 at offset 0.
- Backpressure: vector_valid pulsed while ready=0 (during EMIT or DONE) -> no capture, no output_done, index unchanged.

Source files
------------

// File: rtl/mac_skew_feeder_pkg.sv
// Shared types and sizing helpers for the systolic MAC array edge feeders.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_skew_feeder_pkg;

    // Default bits per array element.
    localparam int DATA_WIDTH = 8;

    // Control states shared by the feeders, MAC array and activation layer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Maximum number of vectors in one batch: one per possible skew offset.
    function automatic int calc_n(input int in_dim, input int out_dim);
        return out_dim - in_dim + 1;
    endfunction

    // Index counter width; it must be able to hold the value N itself.
    function automatic int idx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mac_skew_feeder_if.sv
// Producer/consumer bundle for one skew feeder edge.
// Latency: n/a (wiring only).
// Backpressure: producer presents vectors only while ready is high.
interface mac_skew_feeder_if #(
    parameter int DATA_WIDTH = mac_skew_feeder_pkg::DATA_WIDTH,
    parameter int IN_DIM     = 16,
    parameter int OUT_DIM    = 64
);
    logic                          start;
    logic                          vector_valid;
    logic                          vectors_complete;
    logic [DATA_WIDTH*IN_DIM-1:0]  in_vector;
    logic [DATA_WIDTH*OUT_DIM-1:0] out_vector;
    logic                          ready;
    logic                          output_done;
    logic                          all_done;

    // Feeder side.
    modport slave (
        input  start, vector_valid, vectors_complete, in_vector,
        output out_vector, ready, output_done, all_done
    );

    // Producer / array side.
    modport master (
        output start, vector_valid, vectors_complete, in_vector,
        input  out_vector, ready, output_done, all_done
    );
endinterface

// File: rtl/mac_skew_feeder_skew_shifter.sv
// Places an IN_DIM-element vector at an element offset inside a zero OUT_DIM row.
// Latency: combinational.
// Backpressure: none.
module mac_skew_feeder_skew_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_DIM     = 16,
    parameter int OUT_DIM    = 64,
    parameter int OFF_W      = 6
) (
    input  logic [DATA_WIDTH*IN_DIM-1:0]  in_vector,
    input  logic [OFF_W-1:0]              offset,
    output logic [DATA_WIDTH*OUT_DIM-1:0] out_vector
);
    localparam int OUT_W = DATA_WIDTH * OUT_DIM;

    // Zero-extend to the row width, then slide up by whole elements; the
    // vacated low elements and untouched high elements stay zero.
    always_comb begin
        out_vector = OUT_W'(in_vector) << (DATA_WIDTH * int'(offset));
    end
endmodule

// File: rtl/mac_skew_feeder.sv
// Edge feeder: k-th input vector becomes a row shifted by k elements, zero-filled.
// Latency: 1 cycle from capture to output_done; at most one vector per 2 cycles.
// Backpressure: ready is high only in WAIT; vector_valid is ignored otherwise.
module mac_skew_feeder
    import mac_skew_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = mac_skew_feeder_pkg::DATA_WIDTH,
    parameter int IN_DIM     = 16,
    parameter int OUT_DIM    = 64
) (
    input  logic          clk,
    input  logic          rst,
    mac_skew_feeder_if.slave bus
);
    localparam int N     = calc_n(IN_DIM, OUT_DIM);
    localparam int IDX_W = idx_width(N);
    localparam int OUT_W = DATA_WIDTH * OUT_DIM;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   index, index_nxt;
    logic               capture;
    logic [OUT_W-1:0]   skewed;
    logic [OUT_W-1:0]   out_q;
    logic               ready_q;
    logic               done_q;
    logic               all_done_q;

    // Row placement uses the current index as the skew offset.
    mac_skew_feeder_skew_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_DIM     (IN_DIM),
        .OUT_DIM    (OUT_DIM),
        .OFF_W      (IDX_W)
    ) u_shifter (
        .in_vector  (bus.in_vector),
        .offset     (index),
        .out_vector (skewed)
    );

    // Next-state logic; start overrides everything, including a pending capture.
    always_comb begin
        state_nxt = state;
        index_nxt = index;
        capture   = 1'b0;
        if (bus.start) begin
            state_nxt = WAIT;
            index_nxt = '0;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                WAIT: begin
                    if (bus.vector_valid) begin
                        capture   = 1'b1;
                        state_nxt = EMIT;
                    end else if (bus.vectors_complete) begin
                        state_nxt = DONE;
                    end
                end
                EMIT: begin
                    index_nxt = index + IDX_W'(1);
                    if (bus.vectors_complete || (int'(index) + 1 >= N))
                        state_nxt = DONE;
                    else
                        state_nxt = WAIT;
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, index and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            index      <= '0;
            out_q      <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            index      <= index_nxt;
            ready_q    <= (state_nxt == WAIT);
            done_q     <= (state_nxt == EMIT);
            all_done_q <= (state_nxt == DONE);
            if (bus.start)
                out_q <= '0;
            else if (capture)
                out_q <= skewed;
        end
    end

    assign bus.out_vector  = out_q;
    assign bus.ready       = ready_q;
    assign bus.output_done = done_q;
    assign bus.all_done    = all_done_q;
endmodule

// File: tb/tb_mac_skew_feeder.sv
// Self-checking bench for mac_skew_feeder with IN_DIM=4, OUT_DIM=6 (N=3).
// Expected rows are queued when a vector is driven and checked on output_done.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mac_skew_feeder;
    localparam int DW  = 8;
    localparam int IND = 4;
    localparam int OD  = 6;

    typedef struct {
        logic [DW*IND-1:0] vec;
        logic [DW*OD-1:0]  exp;
    } vec_rec_t;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    logic [DW*OD-1:0] sb[$];
    vec_rec_t tbl[3];

    mac_skew_feeder_if #(.DATA_WIDTH(DW), .IN_DIM(IND), .OUT_DIM(OD)) bus();

    mac_skew_feeder #(.DATA_WIDTH(DW), .IN_DIM(IND), .OUT_DIM(OD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every output_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && bus.output_done) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output_done: out=%h with nothing pending", bus.out_vector);
            end else begin
                logic [DW*OD-1:0] e;
                e = sb.pop_front();
                if (bus.out_vector !== e) begin
                    fails++;
                    $display("FAIL row: got %h, expected %h", bus.out_vector, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(bus.ready), 64'd1);
    endtask

    // Present one vector for one cycle; returns on the falling edge of EMIT.
    task automatic send_vec(input logic [DW*IND-1:0] v, input logic [DW*OD-1:0] e, input logic cmpl);
        wait_ready();
        bus.in_vector        = v;
        bus.vector_valid     = 1'b1;
        bus.vectors_complete = cmpl;
        sb.push_back(e);
        @(negedge clk);
        bus.vector_valid = 1'b0;
        chk("output_done_latency", 64'(bus.output_done), 64'd1);
        chk("ready_low_in_emit", 64'(bus.ready), 64'd0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        tbl[0] = '{vec: 32'h04030201, exp: 48'h000004030201};
        tbl[1] = '{vec: 32'h08070605, exp: 48'h000807060500};
        tbl[2] = '{vec: 32'h0C0B0A09, exp: 48'h0C0B0A090000};

        rst = 1'b0;
        bus.start = 1'b0;
        bus.vector_valid = 1'b0;
        bus.vectors_complete = 1'b0;
        bus.in_vector = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_vector", 64'(bus.out_vector), 64'd0);
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_output_done", 64'(bus.output_done), 64'd0);
        chk("rst_all_done", 64'(bus.all_done), 64'd0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_out_vector", 64'(bus.out_vector), 64'd0);
        chk("idle_ready", 64'(bus.ready), 64'd0);
        chk("idle_all_done", 64'(bus.all_done), 64'd0);

        // Full three-vector batch from the table.
        pulse_start();
        chk("ready_after_start", 64'(bus.ready), 64'd1);
        for (int i = 0; i < 3; i++)
            send_vec(tbl[i].vec, tbl[i].exp, 1'b0);
        @(negedge clk);
        chk("batch_all_done", 64'(bus.all_done), 64'd1);
        chk("batch_ready_low", 64'(bus.ready), 64'd0);
        chk("batch_out_held", 64'(bus.out_vector), 64'h0C0B0A090000);

        // Vectors offered in DONE must be ignored.
        bus.in_vector = 32'hFFFFFFFF;
        bus.vector_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.vector_valid = 1'b0;
        chk("done_bp_out_held", 64'(bus.out_vector), 64'h0C0B0A090000);
        chk("done_bp_all_done", 64'(bus.all_done), 64'd1);
        chk("done_bp_ready", 64'(bus.ready), 64'd0);

        // Early complete after a single vector.
        pulse_start();
        chk("restart_out_clear", 64'(bus.out_vector), 64'd0);
        chk("restart_all_done_clear", 64'(bus.all_done), 64'd0);
        send_vec(32'h44332211, 48'h000044332211, 1'b0);
        bus.vectors_complete = 1'b1;
        @(negedge clk);
        chk("early_all_done", 64'(bus.all_done), 64'd1);
        repeat (2) @(negedge clk);
        chk("early_out_held", 64'(bus.out_vector), 64'h000044332211);
        chk("early_ready", 64'(bus.ready), 64'd0);

        // Valid and complete in the same cycle.
        bus.vectors_complete = 1'b0;
        pulse_start();
        send_vec(32'hDDCCBBAA, 48'h0000DDCCBBAA, 1'b1);
        @(negedge clk);
        chk("simul_all_done", 64'(bus.all_done), 64'd1);
        chk("simul_out", 64'(bus.out_vector), 64'h0000DDCCBBAA);
        bus.vectors_complete = 1'b0;

        // Restart mid-batch after one row.
        pulse_start();
        send_vec(32'h11223344, 48'h000011223344, 1'b0);
        @(negedge clk);
        pulse_start();
        chk("mid_restart_out", 64'(bus.out_vector), 64'd0);
        chk("mid_restart_all_done", 64'(bus.all_done), 64'd0);
        chk("mid_restart_ready", 64'(bus.ready), 64'd1);

        // Start together with a valid vector discards the capture.
        bus.in_vector = 32'hEEEEEEEE;
        bus.vector_valid = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.vector_valid = 1'b0;
        bus.start = 1'b0;
        chk("start_kill_output_done", 64'(bus.output_done), 64'd0);
        chk("start_kill_out", 64'(bus.out_vector), 64'd0);

        send_vec(32'h01010101, 48'h000001010101, 1'b0);
        @(negedge clk);

        // Valid held through EMIT: only one capture, index advances once.
        wait_ready();
        bus.in_vector = 32'h05040302;
        bus.vector_valid = 1'b1;
        sb.push_back(48'h000504030200);
        @(negedge clk);
        chk("held_output_done", 64'(bus.output_done), 64'd1);
        @(negedge clk);
        bus.vector_valid = 1'b0;
        chk("held_no_second_pulse", 64'(bus.output_done), 64'd0);
        chk("held_ready_back", 64'(bus.ready), 64'd1);
        send_vec(32'h0D0C0B0A, 48'h0D0C0B0A0000, 1'b0);
        @(negedge clk);
        chk("held_batch_all_done", 64'(bus.all_done), 64'd1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
